// File: rtl/opu_seq_pkg.sv
// Shared types and constants for the reflect sweep sequencer.
package opu_seq_pkg;

  localparam int TYPE_W       = 4;
  localparam int LOOP_LEN_M0  = 12;
  localparam int LOOP_LEN_M12 = 3;

  localparam int MODE_B0 = 0;
  localparam int MODE_B1 = 1;
  localparam int MODE_B2 = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_DWELL  = 3'd2,
    ST_STEP   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5,
    ST_ABORT  = 3'd6
  } seq_state_e;

  // Bit0 takes priority and selects the long loop; bit1/bit2 select the short loop.
  function automatic logic [TYPE_W-1:0] last_type_idx(input logic [3:0] mode);
    return mode[MODE_B0] ? TYPE_W'(LOOP_LEN_M0 - 1) : TYPE_W'(LOOP_LEN_M12 - 1);
  endfunction

  function automatic logic mode_valid(input logic [3:0] mode);
    return mode[MODE_B0] | mode[MODE_B1] | mode[MODE_B2];
  endfunction

endpackage

// File: rtl/opu_seq_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module opu_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/opu_reflect_sequencer.sv
// Runs one reflect sweep per start: clear, then dwell/step/settle per type, then done.
module opu_reflect_sequencer
  import opu_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [3:0]       mode_i,
  input  logic [CNT_W-1:0] dwell_i,
  input  logic [CNT_W-1:0] settle_i,
  output logic [3:0]       mode_o,
  output logic             ctrl_reset_o,
  output logic             ctrl_update_o,
  output logic             active_o,
  output logic [3:0]       type_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  seq_state_e        state_q, next_state;
  logic [3:0]        mode_q;
  logic [CNT_W-1:0]  dwell_q, settle_q;
  logic [TYPE_W-1:0] idx_q;
  logic              err_q;

  logic              tmr_load, tmr_dec, tmr_expired;
  logic [CNT_W-1:0]  tmr_val;
  logic              accept;

  assign accept = (state_q == ST_IDLE) && start_i && mode_valid(mode_i);

  // Dwell and settle never overlap, so one timer serves both phases.
  opu_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .SYS_CLK  (SYS_CLK),
    .SYS_RST  (SYS_RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expired  (tmr_expired)
  );

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Timer is loaded with count-1 so the phase lasts exactly the latched number of cycles.
  always_comb begin
    next_state = state_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    tmr_val    = dwell_q - CNT_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (accept) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        next_state = ST_DWELL;
        tmr_load   = 1'b1;
      end
      ST_DWELL: begin
        tmr_dec = 1'b1;
        if (tmr_expired) next_state = ST_STEP;
      end
      ST_STEP: begin
        if (idx_q == last_type_idx(mode_q)) begin
          next_state = ST_DONE;
        end else if (settle_q == '0) begin
          next_state = ST_DWELL;
          tmr_load   = 1'b1;
        end else begin
          next_state = ST_SETTLE;
          tmr_load   = 1'b1;
          tmr_val    = settle_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_expired) begin
          next_state = ST_DWELL;
          tmr_load   = 1'b1;
        end
      end
      ST_DONE:  next_state = ST_IDLE;
      ST_ABORT: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    if (abort_i && (state_q != ST_IDLE) && (state_q != ST_ABORT)) begin
      next_state = ST_ABORT;
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      mode_q   <= '0;
      dwell_q  <= CNT_W'(1);
      settle_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state_q == ST_IDLE) && start_i && !mode_valid(mode_i);
      if (accept) begin
        mode_q   <= mode_i;
        dwell_q  <= (dwell_i == '0) ? CNT_W'(1) : dwell_i;
        settle_q <= settle_i;
      end
    end
  end

  // Shadow of the downstream type counter, including its wrap on the final step.
  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      idx_q <= '0;
    end else if ((next_state == ST_CLEAR) || (next_state == ST_ABORT)) begin
      idx_q <= '0;
    end else if (state_q == ST_STEP) begin
      idx_q <= (idx_q == last_type_idx(mode_q)) ? '0 : idx_q + TYPE_W'(1);
    end
  end

  assign mode_o        = mode_q;
  assign type_idx_o    = idx_q;
  assign err_o         = err_q;
  assign ctrl_reset_o  = (state_q == ST_CLEAR) || (state_q == ST_ABORT);
  assign ctrl_update_o = (state_q == ST_STEP);
  assign active_o      = (state_q == ST_DWELL);
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_DONE);

endmodule

// File: tb/tb_opu_reflect_sequencer.sv
// Self-checking bench: per-cycle comparison against a schedule-based sweep model plus literal timing pins.
module tb_opu_reflect_sequencer;

  localparam int CNT_W = 16;

  logic             SYS_CLK = 1'b0;
  logic             SYS_RST = 1'b0;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [3:0]       mode_i = '0;
  logic [CNT_W-1:0] dwell_i = '0;
  logic [CNT_W-1:0] settle_i = '0;
  logic [3:0]       mode_o;
  logic             ctrl_reset_o, ctrl_update_o, active_o, busy_o, done_o, err_o;
  logic [3:0]       type_idx_o;

  opu_reflect_sequencer #(.CNT_W(CNT_W)) dut (
    .SYS_CLK       (SYS_CLK),
    .SYS_RST       (SYS_RST),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .mode_i        (mode_i),
    .dwell_i       (dwell_i),
    .settle_i      (settle_i),
    .mode_o        (mode_o),
    .ctrl_reset_o  (ctrl_reset_o),
    .ctrl_update_o (ctrl_update_o),
    .active_o      (active_o),
    .type_idx_o    (type_idx_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int cyc = 0;
  always @(posedge SYS_CLK) cyc++;

  int compared = 0;
  int mismatched = 0;

  // One entry per future cycle of the sweep in progress; empty means idle.
  typedef struct packed {
    logic       rst, upd, act, busy, done, abrt;
    logic [3:0] idx;
  } exp_t;

  exp_t       sched[$];
  logic [3:0] mode_m = '0;
  logic       err_m = 1'b0;

  int         rst_cyc[$], upd_cyc[$], done_cyc[$];
  logic [3:0] idx_at_upd[$], idx_at_done[$], idx_at_rst[$];
  int         err_cnt = 0, busy_cnt = 0;
  int         c0 = 0;
  int         last_cyc = 0;

  function automatic exp_t vec(input logic rst, upd, act, done, abrt, input int idx);
    exp_t v;
    v.rst = rst; v.upd = upd; v.act = act; v.busy = 1'b1;
    v.done = done; v.abrt = abrt; v.idx = 4'(idx);
    return v;
  endfunction

  task automatic pushSweep(input logic [3:0] m, input int d, input int s);
    int len = m[0] ? 12 : 3;
    int dw = (d == 0) ? 1 : d;
    sched.push_back(vec(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < dw; k++) sched.push_back(vec(0, 0, 1, 0, 0, i));
      sched.push_back(vec(0, 1, 0, 0, 0, i));
      if (i < len - 1)
        for (int k = 0; k < s; k++) sched.push_back(vec(0, 0, 0, 0, 0, i + 1));
    end
    sched.push_back(vec(0, 0, 0, 1, 0, 0));
  endtask

  task automatic checkVal(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic checkOutput();
    exp_t         cur;
    logic [13:0]  exp_bus, dut_bus;
    if (!SYS_RST) begin
      sched.delete();
      mode_m = '0;
      err_m  = 1'b0;
      cur    = '0;
    end else begin
      cur = (sched.size() != 0) ? sched[0] : '0;
    end
    exp_bus = {cur.rst, cur.upd, cur.act, cur.busy, cur.done, err_m, cur.idx, mode_m};
    dut_bus = {ctrl_reset_o, ctrl_update_o, active_o, busy_o, done_o, err_o, type_idx_o, mode_o};
    compared++;
    if (exp_bus !== dut_bus) begin
      mismatched++;
      $display("[TB] FAIL outputs cycle %0d: got rst=%b upd=%b act=%b busy=%b done=%b err=%b idx=%0d mode=%b, want rst=%b upd=%b act=%b busy=%b done=%b err=%b idx=%0d mode=%b",
               cyc, ctrl_reset_o, ctrl_update_o, active_o, busy_o, done_o, err_o, type_idx_o, mode_o,
               cur.rst, cur.upd, cur.act, cur.busy, cur.done, err_m, cur.idx, mode_m);
    end
    if (ctrl_reset_o)  begin rst_cyc.push_back(cyc); idx_at_rst.push_back(type_idx_o); end
    if (ctrl_update_o) begin upd_cyc.push_back(cyc); idx_at_upd.push_back(type_idx_o); end
    if (done_o)        begin done_cyc.push_back(cyc); idx_at_done.push_back(type_idx_o); end
    if (err_o)  err_cnt++;
    if (busy_o) busy_cnt++;
    if (SYS_RST) begin
      if (sched.size() != 0) begin
        exp_t c = sched.pop_front();
        err_m = 1'b0;
        if (abort_i && !c.abrt) begin
          sched.delete();
          sched.push_back(vec(1, 0, 0, 0, 1, 0));
        end
      end else begin
        err_m = start_i && (mode_i[2:0] == 3'b000);
        if (start_i && (mode_i[2:0] != 3'b000)) begin
          mode_m = mode_i;
          pushSweep(mode_i, int'(dwell_i), int'(settle_i));
        end
      end
    end
  endtask

  always @(negedge SYS_CLK) checkOutput();

  task automatic applyStimulus(input logic st, input logic ab, input logic [3:0] m,
                               input int d, input int s);
    @(posedge SYS_CLK);
    #1;
    start_i  = st;
    abort_i  = ab;
    mode_i   = m;
    dwell_i  = CNT_W'(d);
    settle_i = CNT_W'(s);
    last_cyc = cyc;
  endtask

  task automatic clearLogs();
    rst_cyc.delete(); upd_cyc.delete(); done_cyc.delete();
    idx_at_upd.delete(); idx_at_done.delete(); idx_at_rst.delete();
    err_cnt = 0; busy_cnt = 0;
  endtask

  // Config inputs are scrambled while busy; the latched values must not move.
  task automatic waitIdle(input int budget);
    int n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 4'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));
      n++;
    end while (busy_o && n < budget);
    if (busy_o) checkVal("wait_idle_timeout", 1, 0);
  endtask

  function automatic int at(input int q[$], input int k, input int base);
    return (q.size() > k) ? q[k] - base : -1;
  endfunction

  function automatic int atIdx(input logic [3:0] q[$], input int k);
    return (q.size() > k) ? int'(q[k]) : -1;
  endfunction

  task automatic runScenario1();
    clearLogs();
    applyStimulus(1'b1, 1'b0, 4'b0010, 4, 2);
    c0 = last_cyc;
    waitIdle(100);
    checkVal("s1_rst_count", rst_cyc.size(), 1);
    checkVal("s1_rst_at", at(rst_cyc, 0, c0), 1);
    checkVal("s1_upd_count", upd_cyc.size(), 3);
    checkVal("s1_upd0_at", at(upd_cyc, 0, c0), 6);
    checkVal("s1_upd1_at", at(upd_cyc, 1, c0), 13);
    checkVal("s1_upd2_at", at(upd_cyc, 2, c0), 20);
    checkVal("s1_done_at", at(done_cyc, 0, c0), 21);
    checkVal("s1_idx0", atIdx(idx_at_upd, 0), 0);
    checkVal("s1_idx1", atIdx(idx_at_upd, 1), 1);
    checkVal("s1_idx2", atIdx(idx_at_upd, 2), 2);
    checkVal("s1_idx_done", atIdx(idx_at_done, 0), 0);
  endtask

  initial begin
    repeat (3) @(posedge SYS_CLK);
    #1 SYS_RST = 1'b1;
    #1;
    checkVal("reset_busy", int'(busy_o), 0);
    checkVal("reset_mode", int'(mode_o), 0);
    checkVal("reset_idx", int'(type_idx_o), 0);
    checkVal("reset_pulses", int'({ctrl_reset_o, ctrl_update_o, active_o, done_o, err_o}), 0);

    runScenario1();

    clearLogs();
    applyStimulus(1'b1, 1'b0, 4'b0001, 1, 0);
    c0 = last_cyc;
    waitIdle(100);
    checkVal("m1_upd_count", upd_cyc.size(), 12);
    checkVal("m1_upd_first", at(upd_cyc, 0, c0), 3);
    for (int k = 1; k < 12; k++)
      checkVal("m1_upd_spacing", at(upd_cyc, k, c0) - at(upd_cyc, k - 1, c0), 2);
    checkVal("m1_idx_last", atIdx(idx_at_upd, 11), 11);
    checkVal("m1_done_after_last", at(done_cyc, 0, c0) - at(upd_cyc, 11, c0), 1);
    checkVal("m1_idx_done", atIdx(idx_at_done, 0), 0);

    clearLogs();
    applyStimulus(1'b1, 1'b0, 4'b0011, 2, 1);
    waitIdle(150);
    checkVal("prio_upd_count", upd_cyc.size(), 12);
    checkVal("prio_mode_o", int'(mode_o), 3);

    clearLogs();
    applyStimulus(1'b1, 1'b0, 4'b1000, 3, 3);
    repeat (3) applyStimulus(1'b0, 1'b0, 4'b0000, 0, 0);
    checkVal("err_count", err_cnt, 1);
    checkVal("err_busy", busy_cnt, 0);
    checkVal("err_ctrl", rst_cyc.size() + upd_cyc.size(), 0);
    checkVal("err_mode_kept", int'(mode_o), 3);

    clearLogs();
    applyStimulus(1'b1, 1'b0, 4'b0010, 4, 2);
    c0 = last_cyc;
    repeat (9) applyStimulus(1'b0, 1'b0, 4'b0010, 4, 2);
    applyStimulus(1'b0, 1'b1, 4'b0010, 4, 2);
    waitIdle(20);
    checkVal("abort_no_done", done_cyc.size(), 0);
    checkVal("abort_rst_count", rst_cyc.size(), 2);
    checkVal("abort_rst_at", at(rst_cyc, 1, c0), 11);
    checkVal("abort_idx", atIdx(idx_at_rst, 1), 0);
    runScenario1();

    clearLogs();
    applyStimulus(1'b1, 1'b0, 4'b0100, 0, 1);
    c0 = last_cyc;
    waitIdle(50);
    checkVal("dw0_upd0_at", at(upd_cyc, 0, c0), 3);
    checkVal("dw0_upd2_at", at(upd_cyc, 2, c0), 9);
    checkVal("dw0_done_at", at(done_cyc, 0, c0), 10);

    clearLogs();
    applyStimulus(1'b1, 1'b0, 4'b0010, 1, 0);
    c0 = last_cyc;
    repeat (11) applyStimulus(1'b1, 1'b0, 4'b0010, 1, 0);
    waitIdle(50);
    checkVal("hold_rst1_at", at(rst_cyc, 1, c0), 10);
    checkVal("hold_done0_at", at(done_cyc, 0, c0), 8);
    checkVal("hold_done_count", done_cyc.size(), 2);

    clearLogs();
    applyStimulus(1'b1, 1'b0, 4'b0010, 4, 2);
    repeat (6) applyStimulus(1'b0, 1'b0, 4'b0010, 4, 2);
    applyStimulus(1'b0, 1'b0, 4'b0010, 4, 2);
    #1 SYS_RST = 1'b0;
    #1;
    checkVal("rst_mid_busy", int'(busy_o), 0);
    checkVal("rst_mid_idx", int'(type_idx_o), 0);
    checkVal("rst_mid_mode", int'(mode_o), 0);
    checkVal("rst_mid_pulses", int'({ctrl_reset_o, ctrl_update_o, active_o, done_o, err_o}), 0);
    @(posedge SYS_CLK);
    #1 SYS_RST = 1'b1;

    for (int n = 0; n < 2500; n++) begin
      logic [3:0] m;
      case ($urandom_range(0, 7))
        0: m = 4'b0001;
        1: m = 4'b0010;
        2: m = 4'b0100;
        3: m = 4'b0011;
        4: m = 4'b1000;
        5: m = 4'b0000;
        default: m = 4'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0), m,
                    $urandom_range(0, 4), $urandom_range(0, 3));
    end
    waitIdle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
